dual_port_bram_be: RTL and testbench

- Parametrised true dual-port block RAM with per-byte write enables and a configurable read latency (1 or 2 cycles).
- Selectable read-during-write mode, byte-wise write-collision arbitration and a self-clearing initialisation sweep after reset.
- Drop-in memory macro for cache data/tag arrays and main memory; one port serves the core side, the other the fill/DMA side.

---
 rtl/dual_port_bram_be.sv | 184 ++++++++++++++++++
 tb/tb_dual_port_bram_be.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_bram_be.sv
// True dual-port byte-enabled RAM with a clear sweep after reset and a 1- or 2-cycle read pipeline.
// Defining BRAM_SCAN_TRACE_EN adds a negedge cycle counter and a per-cycle debug trace gated by scan.
module dual_port_bram_be #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int READ_LATENCY    = 1,
    parameter int WRITE_MODE      = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000,
    localparam int NB             = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  readEnable_1,
    input  logic                  writeEnable_1,
    input  logic [NB-1:0]         byteEnable_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] writeData_1,
    output logic [DATA_WIDTH-1:0] readData_1,
    output logic                  readValid_1,
    input  logic                  readEnable_2,
    input  logic                  writeEnable_2,
    input  logic [NB-1:0]         byteEnable_2,
    input  logic [ADDR_WIDTH-1:0] address_2,
    input  logic [DATA_WIDTH-1:0] writeData_2,
    output logic [DATA_WIDTH-1:0] readData_2,
    output logic                  readValid_2,
    output logic                  collision,
    input  logic                  scan
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic                    ready_q, ready_d;
    logic                    collision_q;
    logic [DATA_WIDTH-1:0]   ram [RAM_DEPTH];

    logic                         accept;
    logic [1:0]                   re, we, rv;
    logic [1:0][NB-1:0]           be;
    logic [1:0][ADDR_WIDTH-1:0]   addr;
    logic [1:0][DATA_WIDTH-1:0]   wd, rd;

    // Index 0 is port 1, index 1 is port 2.
    assign re     = {readEnable_2, readEnable_1};
    assign we     = {writeEnable_2, writeEnable_1};
    assign be     = {byteEnable_2, byteEnable_1};
    assign addr   = {address_2, address_1};
    assign wd     = {writeData_2, writeData_1};
    assign accept = (state_q == ST_READY) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            clear_addr_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            ready_q      <= ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        ready_d      = ready_q;
        case (state_q)
            ST_INIT: begin
                clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                if (clear_addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: ;
            default:  state_d = ST_INIT;
        endcase
    end

    // Port 1 is written last so it owns any lane both ports enable.
    always_ff @(posedge clock) begin
        if (!reset && state_q == ST_INIT) begin
            ram[clear_addr_q] <= INIT_VALUE;
        end else if (accept) begin
            for (int i = 0; i < NB; i++) begin
                if (we[1] && be[1][i])
                    ram[addr[1]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[1][i*BYTE_WIDTH +: BYTE_WIDTH];
                if (we[0] && be[0][i])
                    ram[addr[0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[0][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            collision_q <= 1'b0;
        else
            collision_q <= accept && we[0] && we[1] && (addr[0] == addr[1]) && |(be[0] & be[1]);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] s1_data_q;
            logic                  s1_valid_q;

            // Only the port's own write is forwarded; the other port's write is never visible here.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_data_q  <= '0;
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= accept && re[gi];
                    if (accept && re[gi]) begin
                        for (int i = 0; i < NB; i++) begin
                            s1_data_q[i*BYTE_WIDTH +: BYTE_WIDTH] <=
                                (WRITE_MODE == 0 && we[gi] && be[gi][i]) ?
                                wd[gi][i*BYTE_WIDTH +: BYTE_WIDTH] :
                                ram[addr[gi]][i*BYTE_WIDTH +: BYTE_WIDTH];
                        end
                    end
                end
            end

            if (READ_LATENCY == 2) begin : g_lat2
                logic [DATA_WIDTH-1:0] s2_data_q;
                logic                  s2_valid_q;
                always_ff @(posedge clock) begin
                    if (reset) begin
                        s2_data_q  <= '0;
                        s2_valid_q <= 1'b0;
                    end else begin
                        s2_valid_q <= s1_valid_q;
                        if (s1_valid_q)
                            s2_data_q <= s1_data_q;
                    end
                end
                assign rd[gi] = s2_data_q;
                assign rv[gi] = s2_valid_q;
            end else begin : g_lat1
                assign rd[gi] = s1_data_q;
                assign rv[gi] = s1_valid_q;
            end
        end
    endgenerate

    assign ready       = ready_q;
    assign collision   = collision_q;
    assign readData_1  = rd[0];
    assign readValid_1 = rv[0];
    assign readData_2  = rd[1];
    assign readValid_2 = rv[1];

`ifdef BRAM_SCAN_TRACE_EN
    logic [31:0] trace_cycles_q;

    always_ff @(negedge clock) begin
        if (reset)
            trace_cycles_q <= '0;
        else
            trace_cycles_q <= trace_cycles_q + 32'd1;
    end

    always @(negedge clock) begin
        if (scan && trace_cycles_q >= 32'(SCAN_CYCLES_MIN) && trace_cycles_q <= 32'(SCAN_CYCLES_MAX))
            $display("core=%0d cyc=%0d st=%0d rdy=%0b | p1 re=%0b we=%0b be=%h a=%h wd=%h rd=%h rv=%0b | p2 re=%0b we=%0b be=%h a=%h wd=%h rd=%h rv=%0b | col=%0b",
                     CORE, trace_cycles_q, state_q, ready_q,
                     re[0], we[0], be[0], addr[0], wd[0], rd[0], rv[0],
                     re[1], we[1], be[1], addr[1], wd[1], rd[1], rv[1], collision_q);
    end
`else
    logic unused_scan;
    assign unused_scan = scan;
    localparam int unused_trace_cfg = CORE + SCAN_CYCLES_MIN + SCAN_CYCLES_MAX;
`endif

endmodule

// File: tb/tb_dual_port_bram_be.sv
// Drives two RAM builds (latency 1 write-first, latency 2 read-first) with identical stimulus
// and checks every output each cycle against a word-level memory model with scheduled read results.
module tb_dual_port_bram_be;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] INITV = 32'hDEADBEEF;
    localparam int LAT  [2] = '{1, 2};
    localparam int MODE [2] = '{0, 1};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, scan = 1'b0;
    logic        re1 = 0, we1 = 0, re2 = 0, we2 = 0;
    logic [3:0]  be1 = 0, be2 = 0;
    logic [AW-1:0] a1 = 0, a2 = 0;
    logic [31:0] wd1 = 0, wd2 = 0;

    logic        rdy_a, rv1_a, rv2_a, col_a, rdy_b, rv1_b, rv2_b, col_b;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

    dual_port_bram_be #(.ADDR_WIDTH(AW), .INIT_VALUE(INITV), .READ_LATENCY(1), .WRITE_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .ready(rdy_a),
        .readEnable_1(re1), .writeEnable_1(we1), .byteEnable_1(be1), .address_1(a1),
        .writeData_1(wd1), .readData_1(rd1_a), .readValid_1(rv1_a),
        .readEnable_2(re2), .writeEnable_2(we2), .byteEnable_2(be2), .address_2(a2),
        .writeData_2(wd2), .readData_2(rd2_a), .readValid_2(rv2_a),
        .collision(col_a), .scan(scan));

    dual_port_bram_be #(.ADDR_WIDTH(AW), .INIT_VALUE(INITV), .READ_LATENCY(2), .WRITE_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .ready(rdy_b),
        .readEnable_1(re1), .writeEnable_1(we1), .byteEnable_1(be1), .address_1(a1),
        .writeData_1(wd1), .readData_1(rd1_b), .readValid_1(rv1_b),
        .readEnable_2(re2), .writeEnable_2(we2), .byteEnable_2(be2), .address_2(a2),
        .writeData_2(wd2), .readData_2(rd2_b), .readValid_2(rv2_b),
        .collision(col_b), .scan(scan));

    typedef struct {
        int          due;
        int          d;
        int          p;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mem [DEPTH];
    pend_t       pend [$];
    int          cnt = 0, cyc = 0, checks = 0, errors = 0;
    bit          exp_ready = 0, exp_coll = 0;
    bit          exp_v [2][2];
    logic [31:0] exp_d [2][2];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        re1 = 0; we1 = 0; re2 = 0; we2 = 0; be1 = 0; be2 = 0;
    endtask

    task automatic cycle();
        logic [31:0] old1, old2, rv;
        bit acc;
        @(posedge clock);
        if (reset) begin
            cnt = 0; pend.delete(); exp_ready = 0; exp_coll = 0;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) exp_d[d][p] = '0;
        end else begin
            acc = exp_ready;
            if (acc) begin
                old1 = mem[a1];
                old2 = mem[a2];
                for (int d = 0; d < 2; d++) begin
                    if (re1) begin
                        rv = (MODE[d] == 0 && we1) ? merge(old1, wd1, be1) : old1;
                        pend.push_back('{due: cyc + LAT[d], d: d, p: 0, data: rv});
                    end
                    if (re2) begin
                        rv = (MODE[d] == 0 && we2) ? merge(old2, wd2, be2) : old2;
                        pend.push_back('{due: cyc + LAT[d], d: d, p: 1, data: rv});
                    end
                end
                if (we2) mem[a2] = merge(mem[a2], wd2, be2);
                if (we1) mem[a1] = merge(mem[a1], wd1, be1);
            end
            exp_coll = acc && we1 && we2 && (a1 == a2) && ((be1 & be2) != 0);
            if (!exp_ready) begin
                cnt++;
                if (cnt == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) mem[k] = INITV;
                    exp_ready = 1;
                end
            end
        end
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) exp_v[d][p] = 0;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == cyc) begin
                exp_v[pend[k].d][pend[k].p] = 1;
                exp_d[pend[k].d][pend[k].p] = pend[k].data;
                pend.delete(k);
            end
        end
        #1;
        chk("ready_a", 32'(rdy_a), 32'(exp_ready));
        chk("ready_b", 32'(rdy_b), 32'(exp_ready));
        chk("coll_a",  32'(col_a), 32'(exp_coll));
        chk("coll_b",  32'(col_b), 32'(exp_coll));
        chk("rv1_a",   32'(rv1_a), 32'(exp_v[0][0]));
        chk("rv2_a",   32'(rv2_a), 32'(exp_v[0][1]));
        chk("rv1_b",   32'(rv1_b), 32'(exp_v[1][0]));
        chk("rv2_b",   32'(rv2_b), 32'(exp_v[1][1]));
        chk("rd1_a",   rd1_a, exp_d[0][0]);
        chk("rd2_a",   rd2_a, exp_d[0][1]);
        chk("rd1_b",   rd1_b, exp_d[1][0]);
        chk("rd2_b",   rd2_b, exp_d[1][1]);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                exp_v[d][p] = 0;
                exp_d[d][p] = '0;
            end

        // Reset for two cycles, then start the sweep; a write and a read during it are ignored.
        reset = 1; cycle(); cycle();
        reset = 0; repeat (3) cycle();
        we1 = 1; be1 = 4'hF; a1 = 4'd2; wd1 = 32'h12345678; re2 = 1; a2 = 4'd1; cycle(); idle();
        repeat (5) cycle();
        // Sweep is at address 9: reset restarts it from 0.
        reset = 1; cycle(); reset = 0;
        repeat (18) cycle();

        // Read back all addresses on both ports, back to back.
        for (int i = 0; i < DEPTH; i++) begin
            re1 = 1; a1 = AW'(i); re2 = 1; a2 = AW'(DEPTH - 1 - i); cycle();
        end
        idle(); repeat (2) cycle();

        // Byte-lane write over zero.
        we1 = 1; a1 = 4'd3; wd1 = 32'h0; be1 = 4'hF; cycle();
        wd1 = 32'h11223344; be1 = 4'b0101; cycle(); idle();
        re1 = 1; a1 = 4'd3; cycle(); idle(); repeat (2) cycle();

        // Read-during-write on port 1, cross-port read on port 2.
        we1 = 1; a1 = 4'd5; wd1 = 32'hAAAAAAAA; be1 = 4'hF; cycle(); idle();
        re1 = 1; we1 = 1; a1 = 4'd5; wd1 = 32'h55555555; be1 = 4'hF; re2 = 1; a2 = 4'd5; cycle(); idle();
        // Same on port 2 with a partial mask.
        re2 = 1; we2 = 1; a2 = 4'd5; wd2 = 32'h12345678; be2 = 4'b1001; re1 = 1; a1 = 4'd5; cycle(); idle();
        repeat (2) cycle();

        // Overlapping write-write, then disjoint lanes, then different addresses.
        we1 = 1; a1 = 4'd7; wd1 = 32'h0; be1 = 4'hF; cycle(); idle();
        we1 = 1; we2 = 1; a1 = 4'd7; a2 = 4'd7; wd1 = 32'h11111111; wd2 = 32'h22222222;
        be1 = 4'b0011; be2 = 4'b0110; cycle(); idle();
        re1 = 1; a1 = 4'd7; cycle(); idle(); repeat (2) cycle();
        we1 = 1; we2 = 1; a1 = 4'd7; a2 = 4'd7; wd1 = 32'h33333333; wd2 = 32'h44444444;
        be1 = 4'b1100; be2 = 4'b0011; cycle(); idle();
        we1 = 1; we2 = 1; a1 = 4'd8; a2 = 4'd9; be1 = 4'hF; be2 = 4'hF; cycle(); idle();
        re1 = 1; a1 = 4'd7; re2 = 1; a2 = 4'd9; cycle(); idle(); repeat (2) cycle();

        // Pipelined reads of 0,1,2.
        for (int i = 0; i < 3; i++) begin
            re1 = 1; a1 = AW'(i); cycle();
        end
        idle(); repeat (3) cycle();

        // Reset lands between request and the latency-2 result.
        re1 = 1; a1 = 4'd3; re2 = 1; a2 = 4'd4; cycle(); idle();
        reset = 1; cycle(); reset = 0;
        repeat (17) cycle();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            re1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            re2 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
            be1 = 4'($urandom_range(0, 15)); be2 = 4'($urandom_range(0, 15));
            a1  = AW'($urandom_range(0, DEPTH - 1));
            a2  = ($urandom_range(0, 1) == 1) ? a1 : AW'($urandom_range(0, DEPTH - 1));
            wd1 = $urandom; wd2 = $urandom;
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 0; idle(); repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
